// File: rtl/mips_trace_checker.sv
// mips_trace_checker
//   Commit-trace comparator for the MIPS CPU. Every cycle in RUN it compares
//   NCH observed write ports against the expected vector at coVecIdx. It
//   counts mismatching channels, captures the first failure, and flags the
//   end of the trace.
//
//   Optional macro TRACE_CHK_WEMASK_EN:
//     defined   - data/address are compared only when the expected write
//                 enable is set. Idle-bus values are don't-care.
//     undefined - write enable, data and address are compared on every
//                 vector (strict mode).
//
//   Ports
//     clk, ci_rst_n            clock (rising edge), async active-low reset
//     ciStart                  start pulse, accepted in IDLE or DONE
//     diObs{Data,Addr}/ciObsWe observed write ports, channel c at [c*W +: W]
//     coVecIdx                 index into the expected-vector store
//     diExp{Data,Addr}/ciExpWe expected vector at coVecIdx
//     ciExpValid               1 = vector present, 0 = end-of-trace marker
//     coBusy/coDone/coPass     status
//     coErrMask                per-channel mismatch of the last compare
//     coErrCnt                 saturating mismatch count
//     coFirstErr{Idx,Ch,Vld}   first failing vector and its lowest channel
//
//   state  | meaning
//   IDLE   | after reset, waiting for ciStart
//   RUN    | comparing one vector per cycle
//   DONE   | end marker or last index seen; results held
module mips_trace_checker #(
  parameter int LOGWIDTH = 5,
  parameter int NCH      = 2,
  parameter int LOGDEPTH = 13,
  parameter int ERRW     = 16
) (
  input  logic                                        clk,
  input  logic                                        ci_rst_n,
  input  logic                                        ciStart,
  input  logic [NCH*(2**LOGWIDTH)-1:0]                diObsData,
  input  logic [NCH*(2**LOGWIDTH)-1:0]                diObsAddr,
  input  logic [NCH-1:0]                              ciObsWe,
  output logic [LOGDEPTH-1:0]                         coVecIdx,
  input  logic [NCH*(2**LOGWIDTH)-1:0]                diExpData,
  input  logic [NCH*(2**LOGWIDTH)-1:0]                diExpAddr,
  input  logic [NCH-1:0]                              ciExpWe,
  input  logic                                        ciExpValid,
  output logic                                        coBusy,
  output logic                                        coDone,
  output logic                                        coPass,
  output logic [NCH-1:0]                              coErrMask,
  output logic [ERRW-1:0]                             coErrCnt,
  output logic [LOGDEPTH-1:0]                         coFirstErrIdx,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]    coFirstErrCh,
  output logic                                        coFirstErrVld
);

  localparam int W   = 2**LOGWIDTH;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  // Wide enough to hold cnt + popcount without overflow before saturation.
  localparam int SW  = ERRW + $clog2(NCH + 1);
  localparam logic [LOGDEPTH-1:0] IDX_MAX = '1;
  localparam logic [ERRW-1:0]     CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LOGDEPTH-1:0] idx_q, idx_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic [ERRW-1:0]     cnt_q, cnt_d;
  logic [LOGDEPTH-1:0] fidx_q, fidx_d;
  logic [CHW-1:0]      fch_q, fch_d;
  logic                fvld_q, fvld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic [NCH-1:0] we_ne, data_ne, addr_ne, mismatch;
  logic [SW-1:0]  pop, sum;
  logic [ERRW-1:0] cnt_sat;
  logic [CHW-1:0] low_ch;

  always_comb begin
    data_ne = '0;
    addr_ne = '0;
    for (int c = 0; c < NCH; c++) begin
      data_ne[c] = (diExpData[c*W +: W] != diObsData[c*W +: W]);
      addr_ne[c] = (diExpAddr[c*W +: W] != diObsAddr[c*W +: W]);
    end
  end

  assign we_ne = ciExpWe ^ ciObsWe;

`ifdef TRACE_CHK_WEMASK_EN
  // Payload is only meaningful when a write is expected.
  assign mismatch = we_ne | (ciExpWe & (data_ne | addr_ne));
`else
  assign mismatch = we_ne | data_ne | addr_ne;
`endif

  always_comb begin
    pop    = '0;
    low_ch = '0;
    for (int c = 0; c < NCH; c++) pop = pop + SW'(mismatch[c]);
    // Descending scan so the lowest set channel is the last one written.
    for (int c = NCH - 1; c >= 0; c--) begin
      if (mismatch[c]) low_ch = CHW'(c);
    end
  end

  assign sum     = SW'(cnt_q) + pop;
  assign cnt_sat = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[ERRW-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = '0;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    fch_d   = fch_q;
    fvld_d  = fvld_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ciStart) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          fidx_d  = '0;
          fch_d   = '0;
          fvld_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (ciExpValid) begin
          mask_d = mismatch;
          cnt_d  = cnt_sat;
          if (!fvld_q && (|mismatch)) begin
            fidx_d = idx_q;
            fch_d  = low_ch;
            fvld_d = 1'b1;
          end
          // The last index is compared, then the run ends without wrapping.
          if (idx_q == IDX_MAX) state_d = S_DONE;
          else                  idx_d   = idx_q + LOGDEPTH'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge ci_rst_n) begin
    if (!ci_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      fidx_q  <= '0;
      fch_q   <= '0;
      fvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      fch_q   <= fch_d;
      fvld_q  <= fvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign coVecIdx      = idx_q;
  assign coBusy        = busy_q;
  assign coDone        = done_q;
  assign coPass        = pass_q;
  assign coErrMask     = mask_q;
  assign coErrCnt      = cnt_q;
  assign coFirstErrIdx = fidx_q;
  assign coFirstErrCh  = fch_q;
  assign coFirstErrVld = fvld_q;

endmodule
